pipe_ctrl_decoder: RTL and testbench
====================================

// Module: pipe_ctrl_decoder
// PURPOSE
//  Registered successor to the combinational ID-stage decoder. Decodes the RV32I subset
//  (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR) and drives the ID/EX control register.
//  Owns load-use stall detection and multi-slot flush sequencing after a taken branch or jump.
//  Sits between the IF/ID register and the EX stage.
// PARAMETERS
//  XLEN           32  instruction width (opcode/rd/rs1/rs2 fields at fixed RV32 positions)
//  ALUOP_W        2   ALUOp width (codes below; upper bits zero when ALUOP_W > 2)
//  FLUSH_SLOTS    2   bubbles inserted after a flush trigger (1..7)
//  ENABLE_LOADUSE 1   1 = load-use stall logic present; 0 = stall_o tied 0
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_i          in   1        synchronous reset, active-high
//  instr_i        in   XLEN     instruction from IF/ID
//  instr_valid_i  in   1        instr_i holds a real instruction
//  branch_taken_i in   1        EX-stage resolved branch taken (single-cycle pulse)
//  stall_o        out  1        hold PC and IF/ID this cycle (combinational)
//  flush_o        out  1        squash IF/ID this cycle (combinational)
//  illegal_o      out  1        registered: unknown opcode accepted last cycle
//  ex_valid_o     out  1        ID/EX entry is a real instruction
//  ex_branch_o, ex_alusrc_o, ex_regwrite_o, ex_memread_o,
//  ex_memwrite_o, ex_memtoreg_o, ex_jump_o   out  1 each   registered controls
//  ex_aluop_o     out  ALUOP_W  registered ALUOp
//  ex_rd_o        out  5        registered destination register
// BEHAVIOUR
//  Decode table (opcode = instr_i[6:0]); ALUOp: LD/ST 00, BRANCH/JAL/JALR 01, R 10, I-ALU 11.
//   RegWrite = 0 for STORE, BRANCH; 1 for all other legal opcodes.
//   ALUSrc = 1 for LOAD, STORE, I-ALU. MemRead = MemtoReg = 1 only for LOAD. MemWrite = 1 only for STORE.
//   Branch = 1 only for BRANCH (taken/not-taken resolved in EX). Jump = 1 for JAL, JALR.
//  Bubble = all ex_* controls 0, ex_rd_o = 0, ex_valid_o = 0.
//  Latency: instr_i at edge t -> ex_* valid after edge t+1 (one register stage).
//  Reset: all ex_* = 0, illegal_o = 0, flush counter = 0; stall_o = flush_o = 0 in the following cycle.
//  Flush counter fcnt (3 bits):
//   trigger = branch_taken_i | (ex_valid_o & ex_jump_o).
//   trigger: fcnt <= FLUSH_SLOTS-1, flush_o = 1, ID/EX loads bubble.
//   fcnt != 0 without trigger: fcnt decrements, flush_o = 1, ID/EX loads bubble.
//   Trigger while fcnt != 0 reloads; never accumulates or wraps. Total = FLUSH_SLOTS bubbles from the last trigger.
//  Load-use stall:
//   stall_o = ENABLE_LOADUSE & ~flush_o & instr_valid_i & ex_valid_o & ex_memread_o & ex_rd_o != 0
//             & ((uses_rs1 & rs1 == ex_rd_o) | (uses_rs2 & rs2 == ex_rd_o)).
//   uses_rs1: all opcodes except JAL. uses_rs2: R, STORE, BRANCH.
//   Stall loads a bubble; lasts exactly 1 cycle because the bubble has memread 0.
//  Priority: reset > flush > stall > normal load.
//   Simultaneous flush and stall: stall_o = 0.
//  instr_valid_i = 0: ID/EX loads bubble; stall_o = 0.
//  Unknown opcode with instr_valid_i, no flush/stall: ID/EX loads bubble; illegal_o = 1 next cycle.
//   illegal_o = 0 otherwise.
// STRUCTURE
//  pipe_ctrl_pkg: opcode localparams (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR),
//   ALUOP_* constants, ctrl_t packed struct {branch, alusrc, regwrite, aluop, memread, memwrite, memtoreg, jump}.
//  Sub-module ctrl_decode_comb: pure opcode -> {ctrl_t, legal, uses_rs1, uses_rs2}.
//  Top holds the ID/EX register, fcnt, hazard compare, and the bubble mux.
// TESTING
//  1 Reset mid-flush: trigger, then rst_i at fcnt=1 -> after next edge all ex_* = 0, fcnt = 0, flush_o = 0.
//  2 Decode sweep: each legal opcode, valid=1 -> ex_* per table; e.g. 0x00A12023 (sw) -> memwrite=1,
//    alusrc=1, regwrite=0, aluop=00.
//  3 Load-use: lw x5 (0x0002A283) then add x6,x5,x1 (0x00128333) -> stall_o = 1 for one cycle,
//    one bubble, add issues next.
//  4 Dependency not a hazard: lw rd=x0, then add using x0 -> stall_o stays 0.
//  5 Taken branch, FLUSH_SLOTS=2: branch_taken_i pulse -> flush_o high 2 cycles, 2 bubbles.
//    Repeat with a second pulse one cycle later -> flush_o high 3 cycles total.
//  6 Collisions: JAL reaches EX while the next instr hits a load-use match -> flush wins, stall_o = 0.
//    Opcode 0x7F -> bubble, illegal_o = 1 for exactly one cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode encodings, ALUOp codes and the control payload carried in the ID/EX register.
package pipe_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FCNT_W  = 3;
  localparam int unsigned ALUOP_N = 2;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [ALUOP_N-1:0] ALUOP_LDST = 2'b00;
  localparam logic [ALUOP_N-1:0] ALUOP_BR   = 2'b01;
  localparam logic [ALUOP_N-1:0] ALUOP_R    = 2'b10;
  localparam logic [ALUOP_N-1:0] ALUOP_I    = 2'b11;

  typedef struct packed {
    logic               branch;
    logic               alusrc;
    logic               regwrite;
    logic [ALUOP_N-1:0] aluop;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure opcode decoder: control word, legality and which source registers are read.
module ctrl_decode_comb
  import pipe_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o,
  output logic             legal_o,
  output logic             uses_rs1_o,
  output logic             uses_rs2_o
);

  always_comb begin
    ctrl_o     = '0;
    legal_o    = 1'b1;
    uses_rs1_o = (opcode_i != OP_JAL);
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_R;
        uses_rs2_o      = 1'b1;
      end
      OP_IALU: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_I;
      end
      OP_LOAD: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_LDST;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALUOP_LDST;
        ctrl_o.memwrite = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.aluop  = ALUOP_BR;
        uses_rs2_o    = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALUOP_BR;
        ctrl_o.jump     = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// ID-stage decoder with registered ID/EX controls, load-use stall and multi-slot flush.
module pipe_ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ALUOP_W        = 2,
  parameter int unsigned FLUSH_SLOTS    = 2,
  parameter int unsigned ENABLE_LOADUSE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [XLEN-1:0]    instr_i,
  input  logic               instr_valid_i,
  input  logic               branch_taken_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               illegal_o,
  output logic               ex_valid_o,
  output logic               ex_branch_o,
  output logic               ex_alusrc_o,
  output logic               ex_regwrite_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               ex_memtoreg_o,
  output logic               ex_jump_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic [REG_W-1:0]   ex_rd_o
);

  localparam bit                LU_EN      = (ENABLE_LOADUSE != 0);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_SLOTS - 1);

  ctrl_t             dec_ctrl;
  logic              dec_legal, dec_uses_rs1, dec_uses_rs2;
  logic [REG_W-1:0]  rs1, rs2, rd;

  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic              illegal_q, illegal_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              trigger, flush, rs_match, stall;
  logic              unused_instr_bits;

  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign rd  = instr_i[11:7];
  assign unused_instr_bits = ^{instr_i[XLEN-1:25], instr_i[14:12]};

  ctrl_decode_comb u_dec (
    .opcode_i   (instr_i[OPC_W-1:0]),
    .ctrl_o     (dec_ctrl),
    .legal_o    (dec_legal),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2)
  );

  // Hazard detection; flush masks any stall in the same cycle.
  always_comb begin
    trigger  = branch_taken_i | (ex_valid_q & ex_ctrl_q.jump);
    flush    = trigger | (fcnt_q != '0);
    rs_match = (dec_uses_rs1 & (rs1 == ex_rd_q)) | (dec_uses_rs2 & (rs2 == ex_rd_q));
    stall    = LU_EN & ~flush & instr_valid_i & ex_valid_q & ex_ctrl_q.memread
               & (ex_rd_q != '0) & rs_match;
  end

  assign flush_o = flush;
  assign stall_o = stall;

  // Next ID/EX entry and flush counter; anything other than a clean legal issue is a bubble.
  always_comb begin
    ex_ctrl_d  = '0;
    ex_valid_d = 1'b0;
    ex_rd_d    = '0;
    illegal_d  = 1'b0;
    fcnt_d     = fcnt_q;

    if (trigger) begin
      fcnt_d = FCNT_RELOAD;
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - FCNT_W'(1);
    end

    if (!flush && !stall && instr_valid_i) begin
      if (dec_legal) begin
        ex_ctrl_d  = dec_ctrl;
        ex_valid_d = 1'b1;
        ex_rd_d    = rd;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      illegal_q  <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      illegal_q  <= illegal_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign illegal_o     = illegal_q;
  assign ex_valid_o    = ex_valid_q;
  assign ex_branch_o   = ex_ctrl_q.branch;
  assign ex_alusrc_o   = ex_ctrl_q.alusrc;
  assign ex_regwrite_o = ex_ctrl_q.regwrite;
  assign ex_memread_o  = ex_ctrl_q.memread;
  assign ex_memwrite_o = ex_ctrl_q.memwrite;
  assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
  assign ex_jump_o     = ex_ctrl_q.jump;
  assign ex_aluop_o    = ALUOP_W'(ex_ctrl_q.aluop);
  assign ex_rd_o       = ex_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed and random checks of pipe_ctrl_decoder against a rule-level pipeline model.
module tb_pipe_ctrl_decoder;

  localparam int FS = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        stall_o, flush_o, illegal_o, ex_valid_o;
  logic        ex_branch_o, ex_alusrc_o, ex_regwrite_o, ex_memread_o;
  logic        ex_memwrite_o, ex_memtoreg_o, ex_jump_o;
  logic [1:0]  ex_aluop_o;
  logic [4:0]  ex_rd_o;

  pipe_ctrl_decoder dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_i        (instr_i),
    .instr_valid_i  (instr_valid_i),
    .branch_taken_i (branch_taken_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .illegal_o      (illegal_o),
    .ex_valid_o     (ex_valid_o),
    .ex_branch_o    (ex_branch_o),
    .ex_alusrc_o    (ex_alusrc_o),
    .ex_regwrite_o  (ex_regwrite_o),
    .ex_memread_o   (ex_memread_o),
    .ex_memwrite_o  (ex_memwrite_o),
    .ex_memtoreg_o  (ex_memtoreg_o),
    .ex_jump_o      (ex_jump_o),
    .ex_aluop_o     (ex_aluop_o),
    .ex_rd_o        (ex_rd_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model state: {valid,branch,alusrc,regwrite,aluop[1:0],memread,memwrite,memtoreg,jump,rd[4:0]}
  logic [14:0] m_ex  = '0;
  logic        m_ill = 1'b0;
  int          cyc = 0;
  int          last_trig = -100;

  function automatic logic [14:0] obs_ex();
    return {ex_valid_o, ex_branch_o, ex_alusrc_o, ex_regwrite_o, ex_aluop_o,
            ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_jump_o, ex_rd_o};
  endfunction

  // Control word derived from the decode rules, one signal at a time.
  function automatic logic [14:0] m_dec(input logic [31:0] ins, output logic legal,
                                        output logic u1, output logic u2);
    logic [6:0] op;
    logic ld, st, br, jl, jr, r, ia;
    logic [1:0] aop;
    op = ins[6:0];
    ld = (op == 7'h03); st = (op == 7'h23); br = (op == 7'h63);
    jl = (op == 7'h6F); jr = (op == 7'h67); r  = (op == 7'h33); ia = (op == 7'h13);
    legal = ld | st | br | jl | jr | r | ia;
    u1 = ~jl;
    u2 = r | st | br;
    aop = r ? 2'd2 : ia ? 2'd3 : (br | jl | jr) ? 2'd1 : 2'd0;
    return {1'b1, br, ld | st | ia, legal & ~(st | br), aop, ld, st, ld, jl | jr, ins[11:7]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check registered state, apply inputs, check hazard outputs, advance model.
  task automatic step(input logic [31:0] ins, input logic v, input logic bt);
    logic [14:0] d;
    logic legal, u1, u2, trig, mf, ms, hit;
    @(negedge clk_i);
    chk("ex_regs", 16'(obs_ex()), 16'(m_ex));
    chk("illegal", 16'(illegal_o), 16'(m_ill));
    instr_i = ins; instr_valid_i = v; branch_taken_i = bt;
    #1;
    d    = m_dec(ins, legal, u1, u2);
    trig = bt | (m_ex[14] & m_ex[5]);
    if (trig) last_trig = cyc;
    mf   = (cyc - last_trig) < FS;
    hit  = (u1 && ins[19:15] == m_ex[4:0]) || (u2 && ins[24:20] == m_ex[4:0]);
    ms   = !mf && v && m_ex[14] && m_ex[8] && (m_ex[4:0] != 5'd0) && hit;
    chk("flush", 16'(flush_o), 16'(mf));
    chk("stall", 16'(stall_o), 16'(ms));
    m_ill = v && !mf && !ms && !legal;
    m_ex  = (mf || ms || !v || !legal) ? 15'd0 : d;
    cyc++;
  endtask

  // Reset with live inputs (valid add, taken branch) so a missing reset shows up.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; instr_i = 32'h00128333; instr_valid_i = 1'b1; branch_taken_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; instr_i = '0; instr_valid_i = 1'b0; branch_taken_i = 1'b0;
    m_ex = '0; m_ill = 1'b0; cyc = 0; last_trig = -100;
    #1;
    chk("rst_ex", 16'(obs_ex()), 16'd0);
    chk("rst_illegal", 16'(illegal_o), 16'd0);
    chk("rst_flush", 16'(flush_o), 16'd0);
    chk("rst_stall", 16'(stall_o), 16'd0);
  endtask

  localparam logic [31:0] LW_X5  = 32'h0002A283;
  localparam logic [31:0] ADD_DEP = 32'h00128333;

  logic [6:0] op_tab [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F};
  logic [31:0] sweep [7] = '{32'h00A12023, 32'h00128333, 32'h00510093, 32'h0002A283,
                             32'h00208463, 32'h008000EF, 32'h00008067};

  initial begin
    do_reset();

    // Reset while a flush is still pending
    step(32'h0, 1'b0, 1'b1);
    do_reset();

    // Decode sweep; sw is checked field by field once it lands in EX
    step(sweep[0], 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("sw_ctrl", 16'({ex_memwrite_o, ex_alusrc_o, ex_regwrite_o, ex_aluop_o}), 16'b11000);
    for (int i = 1; i < 7; i++) begin
      step(sweep[i], 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(32'h0, 1'b0, 1'b0);
    end

    // Load-use: one stall, one bubble, then the dependent add issues
    do_reset();
    step(LW_X5, 1'b1, 1'b0);
    step(ADD_DEP, 1'b1, 1'b0);
    chk("lu_stall", 16'(stall_o), 16'd1);
    step(ADD_DEP, 1'b1, 1'b0);
    chk("lu_bubble", 16'(ex_valid_o), 16'd0);
    chk("lu_stall_once", 16'(stall_o), 16'd0);
    step(32'h0, 1'b0, 1'b0);
    chk("lu_issue", 16'({ex_valid_o, ex_rd_o, ex_regwrite_o}), 16'b1_00110_1);

    // Load into x0 is never a hazard
    step(32'h00002003, 1'b1, 1'b0);
    step(32'h00100333, 1'b1, 1'b0);
    chk("x0_no_stall", 16'(stall_o), 16'd0);

    // Taken branch: single pulse then back-to-back pulses
    do_reset();
    step(32'h0, 1'b0, 1'b1); chk("br1_c0", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b0); chk("br1_c1", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b0); chk("br1_c2", 16'(flush_o), 16'd0);
    step(32'h0, 1'b0, 1'b1); chk("br2_c0", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b1); chk("br2_c1", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b0); chk("br2_c2", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b0); chk("br2_c3", 16'(flush_o), 16'd0);

    // Collisions: flush beats a load-use match; jump in EX flushes
    step(LW_X5, 1'b1, 1'b0);
    step(ADD_DEP, 1'b1, 1'b1);
    chk("col_flush", 16'(flush_o), 16'd1);
    chk("col_no_stall", 16'(stall_o), 16'd0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h000000EF, 1'b1, 1'b0);
    step(ADD_DEP, 1'b1, 1'b0);
    chk("jal_flush", 16'(flush_o), 16'd1);
    step(32'h0, 1'b0, 1'b0);

    // Illegal opcode: bubble plus a one-cycle illegal_o
    step(32'h0000007F, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("ill_set", 16'({illegal_o, ex_valid_o}), 16'b10);
    step(32'h0, 1'b0, 1'b0);
    chk("ill_clear", 16'(illegal_o), 16'd0);

    // Random traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom_range(0, 3)), op_tab[$urandom_range(0, 7)]};
      step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0);
    end
    step(32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
